// File: rtl/l2_pmem_burst_adaptor.sv
// -----------------------------------------------------------------------------
// l2_pmem_burst_adaptor
//
// Purpose:
//   Sits between the L2 cache's physical-memory line port and a beat-oriented
//   main-memory port. A whole-line read or write request from the L2 turns
//   into a burst of num_beats beats, each s_burst bits wide, toward memory.
//   Read beats are collected into one line. A write-back line is sent out one
//   beat at a time. When the burst is finished, the L2 gets a one-cycle
//   completion pulse.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   line_address_i  L2 line address (byte offset bits ignored)
//   line_read_i     L2 line-fill request, held until line_resp_o
//   line_write_i    L2 write-back request, held until line_resp_o
//   line_wdata_i    line to write back
//   line_rdata_o    assembled fill line (changes only when a read completes)
//   line_resp_o     one-cycle completion pulse
//   mem_address_o   burst base address, stable for the whole burst
//   mem_read_o      burst read request
//   mem_write_o     burst write request
//   mem_wdata_o     current write beat
//   mem_rdata_i     current read beat
//   mem_resp_i      beat accepted / valid this cycle
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module l2_pmem_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_address_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [s_line-1:0]  line_wdata_i,
  output logic [s_line-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [31:0]        mem_address_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [s_burst-1:0] mem_wdata_o,
  input  logic [s_burst-1:0] mem_rdata_i,
  input  logic               mem_resp_i
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam int off_w     = $clog2(s_line / 8);
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [cnt_w-1:0]   count_reg, count_next;
  logic [cnt_w-1:0]   count_inc;
  logic [s_burst-1:0] wbeat_reg [num_beats];
  logic [s_burst-1:0] rbeat_reg [num_beats];
  logic [s_line-1:0]  fill_line;

  logic [31:0]        mem_address_reg, mem_address_next;
  logic               mem_read_reg, mem_read_next;
  logic               mem_write_reg, mem_write_next;
  logic [s_burst-1:0] mem_wdata_reg, mem_wdata_next;
  logic               line_resp_reg, line_resp_next;
  logic [s_line-1:0]  line_rdata_reg, line_rdata_next;

  logic start_write;
  logic start_read;
  logic last_beat;
  logic unused_offset;

  // The byte offset inside a line has no meaning for a whole-line burst.
  assign unused_offset = ^line_address_i[off_w-1:0];

  // A write wins when both requests are raised in the same IDLE cycle.
  assign start_write = (state_reg == IDLE) && line_write_i;
  assign start_read  = (state_reg == IDLE) && !line_write_i && line_read_i;
  assign last_beat   = (count_reg == last_idx);
  assign count_inc   = count_reg + cnt_w'(1);

  // The fill line as it will look once the current beat is stored. When the
  // last beat arrives, the full line is registered straight into
  // line_rdata_o, so it is already valid in the DONE cycle.
  for (genvar gi = 0; gi < num_beats; gi++) begin : g_fill
    assign fill_line[gi*s_burst +: s_burst] =
      (count_reg == cnt_w'(gi)) ? mem_rdata_i : rbeat_reg[gi];
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (line_write_i) begin
          state_next = WRITE;
        end else if (line_read_i) begin
          state_next = READ;
        end
      end
      READ: begin
        if (mem_resp_i && last_beat) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        if (mem_resp_i && last_beat) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values (all outputs are registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next       = count_reg;
    mem_address_next = mem_address_reg;
    mem_read_next    = mem_read_reg;
    mem_write_next   = mem_write_reg;
    mem_wdata_next   = mem_wdata_reg;
    line_resp_next   = 1'b0;
    line_rdata_next  = line_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (start_write) begin
          mem_address_next = {line_address_i[31:off_w], {off_w{1'b0}}};
          mem_write_next   = 1'b1;
          mem_wdata_next   = line_wdata_i[s_burst-1:0];
          count_next       = '0;
        end else if (start_read) begin
          mem_address_next = {line_address_i[31:off_w], {off_w{1'b0}}};
          mem_read_next    = 1'b1;
          count_next       = '0;
        end
      end
      READ: begin
        if (mem_resp_i) begin
          if (last_beat) begin
            mem_read_next   = 1'b0;
            count_next      = '0;
            line_resp_next  = 1'b1;
            line_rdata_next = fill_line;
          end else begin
            count_next = count_inc;
          end
        end
      end
      WRITE: begin
        if (mem_resp_i) begin
          if (last_beat) begin
            mem_write_next = 1'b0;
            count_next     = '0;
            line_resp_next = 1'b1;
          end else begin
            count_next     = count_inc;
            mem_wdata_next = wbeat_reg[count_inc];
          end
        end
      end
      default: begin
        // DONE: line_resp_o falls back to 0 because of the default above.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers: counter, outputs and beat buffers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg       <= '0;
      mem_address_reg <= '0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_wdata_reg   <= '0;
      line_resp_reg   <= 1'b0;
      line_rdata_reg  <= '0;
    end else begin
      count_reg       <= count_next;
      mem_address_reg <= mem_address_next;
      mem_read_reg    <= mem_read_next;
      mem_write_reg   <= mem_write_next;
      mem_wdata_reg   <= mem_wdata_next;
      line_resp_reg   <= line_resp_next;
      line_rdata_reg  <= line_rdata_next;
    end
  end

  // The write buffer captures the whole line at request time. Read beats go
  // into their slot as they arrive. Reset clears both, so beats from an
  // aborted burst cannot end up in a later line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_beats; i++) begin
        wbeat_reg[i] <= '0;
        rbeat_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_beats; i++) begin
        if (start_write) begin
          wbeat_reg[i] <= line_wdata_i[i*s_burst +: s_burst];
        end
        if ((state_reg == READ) && mem_resp_i && (count_reg == cnt_w'(i))) begin
          rbeat_reg[i] <= mem_rdata_i;
        end
      end
    end
  end

  assign line_rdata_o  = line_rdata_reg;
  assign line_resp_o   = line_resp_reg;
  assign mem_address_o = mem_address_reg;
  assign mem_read_o    = mem_read_reg;
  assign mem_write_o   = mem_write_reg;
  assign mem_wdata_o   = mem_wdata_reg;

endmodule

// File: tb/tb_l2_pmem_burst_adaptor.sv
// -----------------------------------------------------------------------------
// tb_l2_pmem_burst_adaptor
//
// Stimulus tasks play the role of both the L2 and main memory. For each line
// transaction they push the expected outcome (burst kind, base address, line)
// and, for writes, the expected beat sequence. A separate negedge monitor
// compares every burst cycle and every completion pulse against those queues.
// -----------------------------------------------------------------------------
module tb_l2_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  mem_address_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_resp_i;

  always #5 clk = ~clk;

  l2_pmem_burst_adaptor dut (
    .clk            (clk),
    .rst            (rst),
    .line_address_i (line_address_i),
    .line_read_i    (line_read_i),
    .line_write_i   (line_write_i),
    .line_wdata_i   (line_wdata_i),
    .line_rdata_o   (line_rdata_o),
    .line_resp_o    (line_resp_o),
    .mem_address_o  (mem_address_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_resp_i     (mem_resp_i)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  base;
    logic [255:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  wbeat_q[$];
  logic [255:0] model_rdata = '0;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           txn_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] dummy;
    if (rst === 1'b0) begin
      if (mem_read_o || mem_write_o) begin
        if (exp_q.size() == 0) begin
          fail("burst_without_request");
        end else begin
          chk("mem_address", 256'(mem_address_o), 256'(exp_q[0].base));
          chk("mem_read", 256'(mem_read_o), 256'(!exp_q[0].wr));
          chk("mem_write", 256'(mem_write_o), 256'(exp_q[0].wr));
          if (mem_write_o) begin
            if (wbeat_q.size() == 0) begin
              fail("extra_write_beat");
            end else begin
              chk("mem_wdata", 256'(mem_wdata_o), 256'(wbeat_q[0]));
              if (mem_resp_i) dummy = wbeat_q.pop_front();
            end
          end
        end
      end
      if (line_resp_o) begin
        if (exp_q.size() == 0) begin
          fail("resp_without_request");
        end else begin
          e = exp_q.pop_front();
          chk("burst_dropped", 256'(mem_read_o | mem_write_o), 256'(0));
          if (e.wr) begin
            chk("write_beats_left", 256'(wbeat_q.size()), 256'(0));
            chk("rdata_after_write", line_rdata_o, model_rdata);
          end else begin
            chk("fill_line", line_rdata_o, e.line);
            model_rdata = e.line;
          end
          txn_no++;
          $display("txn %0d %s base=%h line=%h", txn_no, e.wr ? "write" : "read ", e.base, e.line);
        end
      end else begin
        chk("line_rdata_hold", line_rdata_o, model_rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Every task starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst          = 1'b1;
    mem_resp_i   = 1'b0;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    wbeat_q.delete();
    model_rdata = '0;
    chk("rst_line_rdata", line_rdata_o, 256'(0));
    chk("rst_line_resp", 256'(line_resp_o), 256'(0));
    chk("rst_mem_address", 256'(mem_address_o), 256'(0));
    chk("rst_mem_read", 256'(mem_read_o), 256'(0));
    chk("rst_mem_write", 256'(mem_write_o), 256'(0));
    chk("rst_mem_wdata", 256'(mem_wdata_o), 256'(0));
  endtask

  // gap < 0 : random gap 0..3 before each beat; otherwise a fixed gap.
  // abort_after >= 0 : reset in place of beat number abort_after.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] line, input int gap,
                         input bit wiggle, input int abort_after);
    exp_t e;
    int   waited;
    int   c0;
    int   g;
    e.wr   = wr;
    e.base = addr & 32'hFFFF_FFE0;
    e.line = line;
    exp_q.push_back(e);
    if (wr) for (int k = 0; k < 4; k++) wbeat_q.push_back(line[64*k +: 64]);

    line_address_i = addr;
    line_read_i    = rd;
    line_write_i   = wr;
    line_wdata_i   = wr ? line : rand_line();
    c0 = cyc;

    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(mem_read_o || mem_write_o) && waited < 20);
    if (!(mem_read_o || mem_write_o)) begin
      fail("burst_start_timeout");
      do_reset();
      return;
    end

    for (int k = 0; k < 4; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int j = 0; j < g; j++) begin
        mem_resp_i  = 1'b0;
        mem_rdata_i = rand64();
        @(posedge clk); #1;
      end
      if (abort_after == k) begin
        do_reset();
        return;
      end
      mem_resp_i  = 1'b1;
      mem_rdata_i = wr ? rand64() : line[64*k +: 64];
      if (wiggle && k == 1) begin
        line_address_i = $urandom;
        line_wdata_i   = rand_line();
        if (!wr) line_write_i = 1'b1;
        else     line_read_i  = 1'b1;
      end
      @(posedge clk); #1;
    end
    mem_resp_i  = 1'b0;
    mem_rdata_i = rand64();

    waited = 0;
    while (!line_resp_o && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!line_resp_o) begin
      fail("line_resp_timeout");
      do_reset();
      return;
    end
    if (gap == 0) chk("min_latency", 256'(cyc - c0), 256'(5));
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", 256'(line_resp_o), 256'(0));
  endtask

  initial begin
    logic [255:0] line_a;
    bit wr_r;
    bit rd_r;
    rst            = 1'b1;
    line_address_i = '0;
    line_read_i    = 1'b0;
    line_write_i   = 1'b0;
    line_wdata_i   = '0;
    mem_rdata_i    = '0;
    mem_resp_i     = 1'b0;
    do_reset();

    // Directed read: beats A0..A3 back to back, base 0x1234_5660.
    line_a = {64'hCAFE_F00D_0000_00A3, 64'hCAFE_F00D_0000_00A2,
              64'hCAFE_F00D_0000_00A1, 64'hCAFE_F00D_0000_00A0};
    run_txn(1'b0, 1'b1, 32'h1234_5678, line_a, 0, 1'b0, -1);

    // Write with two idle cycles before each beat.
    run_txn(1'b1, 1'b0, 32'h8000_0040, rand_line(), 2, 1'b0, -1);

    // Both requests at once: the write must win.
    run_txn(1'b1, 1'b1, 32'h0000_1F3C, rand_line(), 0, 1'b0, -1);

    // Reset after two read beats, then a clean read with fresh data.
    run_txn(1'b0, 1'b1, 32'h0BAD_0000, rand_line(), 0, 1'b0, 2);
    run_txn(1'b0, 1'b1, 32'h0BAD_0020, rand_line(), 1, 1'b0, -1);

    // Stray mem_resp_i while idle, then bursts with mid-burst request changes.
    mem_resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata_i = rand64();
      @(posedge clk); #1;
    end
    run_txn(1'b0, 1'b1, 32'h4444_4444, rand_line(), -1, 1'b1, -1);
    run_txn(1'b1, 1'b0, 32'h5555_5555, rand_line(), -1, 1'b1, -1);

    // Two reads back to back: the second request is up in the first IDLE cycle.
    run_txn(1'b0, 1'b1, 32'h0000_0100, rand_line(), 0, 1'b0, -1);
    run_txn(1'b0, 1'b1, 32'h0000_0200, rand_line(), 0, 1'b0, -1);

    // Random mix.
    for (int n = 0; n < 40; n++) begin
      wr_r = 1'($urandom_range(0, 1));
      rd_r = wr_r ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(wr_r, rd_r, $urandom, rand_line(), -1, 1'($urandom_range(0, 1)), -1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("pending_expected", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_pmem_burst_adaptor.md
Name: l2_pmem_burst_adaptor

Overview:
- Responder for the L2 cache's physical-memory line interface: accepts 256-bit line read/write requests (pmem_address, pmem_rdata, write line) from the L2 cache.
- Converts each request into a 4-beat 64-bit burst transaction toward main memory.
- Assembles read bursts into one line; serialises write lines into beats.
- Returns a single-cycle line-complete response to the L2.

Parameters:
- s_line, 256, cache line width in bits
- s_burst, 64, memory beat width in bits
- num_beats, s_line/s_burst (4), beats per line transaction

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- line_address_i  in  32  L2 line address; bits [4:0] ignored
- line_read_i  in  1  L2 requests a line fill; held until line_resp_o
- line_write_i  in  1  L2 requests a line write-back; held until line_resp_o
- line_wdata_i  in  256  line to write back
- line_rdata_o  out  256  assembled fill line
- line_resp_o  out  1  one-cycle completion pulse
- mem_address_o  out  32  burst base address
- mem_read_o  out  1  burst read request
- mem_write_o  out  1  burst write request
- mem_wdata_o  out  64  current write beat
- mem_rdata_i  in  64  current read beat
- mem_resp_i  in  1  beat accepted/valid this cycle

Behaviour:
- Reset: state IDLE, beat counter 0.
  - line_rdata_o = 0, line_resp_o = 0.
  - mem_address_o = 0, mem_read_o = 0, mem_write_o = 0, mem_wdata_o = 0.
- All outputs are registered. Reset mid-transaction aborts it: the next cycle shows the reset values, and partial beats are discarded.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If line_write_i: go to WRITE. Latch line_wdata_i into the write buffer. mem_address_o = {line_address_i[31:5], 5'b0}. mem_write_o = 1. mem_wdata_o = wdata[63:0]. Counter = 0.
  - Else if line_read_i: go to READ. Latch the address the same way. mem_read_o = 1. Counter = 0.
  - If both are asserted, write wins.
- READ:
  - Each cycle with mem_resp_i = 1: store mem_rdata_i into beat slot [counter]. Beat k maps to line bits [64k+63:64k], little-endian. Counter then increments.
  - Cycles without mem_resp_i hold state; gaps between beats are legal.
  - On the beat with counter == num_beats-1: deassert mem_read_o, go to DONE.
- WRITE:
  - mem_wdata_o always shows beat [counter] of the latched line.
  - On mem_resp_i: counter increments and mem_wdata_o advances to the next beat.
  - On the last beat: deassert mem_write_o, go to DONE.
- DONE:
  - line_resp_o = 1 for exactly one cycle, then IDLE.
  - After a read, line_rdata_o already holds the full line in this cycle.
  - line_rdata_o holds until the next read's DONE. Write transactions never modify it.
- mem_address_o is stable for the whole burst.
- line_* request or address changes while not IDLE are ignored.
- mem_resp_i in IDLE or DONE is ignored.
- Counter is 2 bits and wraps only via the state transition; there is no overrun.
- Minimum latency: request sampled at edge 0; mem_read_o/mem_write_o high in cycles 1..4 with back-to-back mem_resp_i; line_resp_o high in cycle 5.
- Back-to-back requests: the L2 drops its request after seeing line_resp_o. A request still high in the first IDLE cycle after DONE starts a new transaction.

Test Plan:
- Read, address 0x1234_5678, beats 0x...A0, A1, A2, A3 on consecutive cycles -> mem_address_o = 0x1234_5660; line_resp_o pulses once in cycle 5; line_rdata_o = {A3, A2, A1, A0}.
- Write, line {D3, D2, D1, D0}, mem_resp_i with 2-cycle gaps between beats -> mem_wdata_o shows D0, D1, D2, D3 in order, each held until its mem_resp_i; mem_write_o drops after the D3 beat; line_resp_o pulses once; line_rdata_o unchanged.
- line_read_i and line_write_i asserted together -> write burst performed; mem_read_o never asserted.
- rst asserted after 2 read beats -> next cycle all outputs zero and state IDLE; a new read completes correctly with fresh data and no stale beats.
- Stray mem_resp_i in IDLE plus request-address change mid-burst -> no counter change and no spurious resp; mem_address_o keeps its latched value.
- Two consecutive reads, second request high in the cycle after DONE -> second burst starts at the next edge; line_rdata_o updates only at the second DONE.
